// File: rtl/seg7_pkg.sv
// Constants shared by the seven-segment scanner: blank code, hex glyph table, slot state.
// Pure declarations; no logic.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low a..g glyphs for 0..F, decimal point excluded.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

endpackage

// File: rtl/seg7_scan_if.sv
// Load bus into the scanner and the digit-select/segment outputs back out.
// No backpressure: load is a fire-and-forget strobe.
interface seg7_scan_if;
  logic        load;
  logic [31:0] data;
  logic [7:0]  dp_en;
  logic [7:0]  digit_en;
  logic [2:0]  sel;
  logic [7:0]  seg;
  logic        frame_tick;

  modport master (output load, data, dp_en, digit_en, input sel, seg, frame_tick);
  modport slave  (input load, data, dp_en, digit_en, output sel, seg, frame_tick);
endinterface

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low seven-segment glyph (a..g); combinational, zero latency.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = HEX_SEG[i_nib];
endmodule

// File: rtl/seg7_scan.sv
// 8-digit multiplexed seven-segment scanner with per-slot blanking and frame-aligned data swap.
// Outputs registered; load is always accepted, display follows at the next frame boundary.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic        clk,
  input logic        rst_n,
  seg7_scan_if.slave bus
);
  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);

  if (BLANK_CYCLES < 1 || CLK_DIV < BLANK_CYCLES + 1) begin : g_param_chk
    $error("seg7_scan: need BLANK_CYCLES >= 1 and CLK_DIV >= BLANK_CYCLES + 1");
  end

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_sel;
  logic [7:0]    r_seg;
  logic          r_frame_tick;
  logic [31:0]   r_pend_data;
  logic [7:0]    r_pend_dp;
  logic [7:0]    r_pend_en;
  logic          r_pend_vld;
  logic [31:0]   r_shd_data;
  logic [7:0]    r_shd_dp;
  logic [7:0]    r_shd_en;

  logic          w_slot_end;
  logic          w_frame_end;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    w_nib;
  logic [6:0]    w_glyph;
  logic [7:0]    w_show_seg;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_sel == 3'd7);
  assign w_cnt_nxt   = w_slot_end ? '0 : r_cnt + CW'(1);
  assign w_nib       = r_shd_data[{r_sel, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  assign w_show_seg = r_shd_en[r_sel] ? {~r_shd_dp[r_sel], w_glyph} : SEG_BLANK;

  // seg is latched once on entering SHOW and held, so it cannot glitch mid-slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_sel        <= 3'd0;
      r_seg        <= SEG_BLANK;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_frame_tick <= w_frame_end;
      if (w_slot_end) r_sel <= r_sel + 3'd1;
      case (r_state)
        ST_BLANK: begin
          if (w_cnt_nxt >= CNT_SHOW) begin
            r_state <= ST_SHOW;
            r_seg   <= w_show_seg;
          end
        end
        ST_SHOW: begin
          if (w_slot_end) begin
            r_state <= ST_BLANK;
            r_seg   <= SEG_BLANK;
          end
        end
      endcase
    end
  end

  // A load in the boundary cycle bypasses pending so it lands in the frame starting now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend_en   <= '0;
      r_pend_vld  <= 1'b0;
      r_shd_data  <= '0;
      r_shd_dp    <= '0;
      r_shd_en    <= 8'hFF;
    end else begin
      if (bus.load) begin
        r_pend_data <= bus.data;
        r_pend_dp   <= bus.dp_en;
        r_pend_en   <= bus.digit_en;
      end
      if (w_frame_end) begin
        r_pend_vld <= 1'b0;
        if (bus.load) begin
          r_shd_data <= bus.data;
          r_shd_dp   <= bus.dp_en;
          r_shd_en   <= bus.digit_en;
        end else if (r_pend_vld) begin
          r_shd_data <= r_pend_data;
          r_shd_dp   <= r_pend_dp;
          r_shd_en   <= r_pend_en;
        end
      end else if (bus.load) begin
        r_pend_vld <= 1'b1;
      end
    end
  end

  assign bus.sel        = r_sel;
  assign bus.seg        = r_seg;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with CLK_DIV=8, BLANK_CYCLES=2; n counts clock edges since reset release.
module tb_seg7_scan;
  logic clk = 1'b0;
  logic rst_n;

  seg7_scan_if bus();

  seg7_scan #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [2:0] sel;
    logic [7:0] seg;
    logic       tick;
  } vec_t;

  vec_t tbl [10];
  int   n;
  int   total;
  int   bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at n=%0d: got %h, want %h", name, n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  task automatic run_to(input int tgt);
    while (n < tgt) step();
  endtask

  task automatic look(input int tgt, input logic [2:0] s, input logic [7:0] g, input string name);
    run_to(tgt);
    chk({name, ".sel"}, bus.sel, s);
    chk({name, ".seg"}, bus.seg, g);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
    bus.load     = 1'b1;
    bus.data     = d;
    bus.dp_en    = dp;
    bus.digit_en = en;
    step();
    bus.load     = 1'b0;
  endtask

  initial begin
    int ticks;

    tbl[0] = '{0,  3'd0, 8'hFF, 1'b0};
    tbl[1] = '{1,  3'd0, 8'hFF, 1'b0};
    tbl[2] = '{2,  3'd0, 8'hC0, 1'b0};
    tbl[3] = '{7,  3'd0, 8'hC0, 1'b0};
    tbl[4] = '{8,  3'd1, 8'hFF, 1'b0};
    tbl[5] = '{10, 3'd1, 8'hC0, 1'b0};
    tbl[6] = '{63, 3'd7, 8'hC0, 1'b0};
    tbl[7] = '{64, 3'd0, 8'hFF, 1'b1};
    tbl[8] = '{65, 3'd0, 8'hFF, 1'b0};
    tbl[9] = '{66, 3'd0, 8'hC0, 1'b0};

    total = 0;
    bad   = 0;
    n     = 0;
    rst_n = 1'b0;
    bus.load     = 1'b0;
    bus.data     = '0;
    bus.dp_en    = '0;
    bus.digit_en = '0;

    #23;
    chk("rst.sel", bus.sel, 3'd0);
    chk("rst.seg", bus.seg, 8'hFF);
    chk("rst.tick", bus.frame_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;

    // Idle scan after reset
    for (int i = 0; i < 10; i++) begin
      run_to(tbl[i].n);
      chk($sformatf("idle%0d.sel", i), bus.sel, tbl[i].sel);
      chk($sformatf("idle%0d.seg", i), bus.seg, tbl[i].seg);
      chk($sformatf("idle%0d.tick", i), bus.frame_tick, tbl[i].tick);
    end

    ticks = 0;
    repeat (64) begin
      step();
      if (bus.frame_tick === 1'b1) ticks++;
    end
    chk("ticks_per_frame", ticks, 1);

    // Mid-frame load shows only from the next frame
    run_to(150);
    do_load(32'h76543210, 8'h01, 8'hFF);
    look(154, 3'd3, 8'hC0, "old3");
    look(191, 3'd7, 8'hC0, "old7");
    look(192, 3'd0, 8'hFF, "edge");
    chk("tick2", bus.frame_tick, 1'b1);
    look(194, 3'd0, 8'h40, "new0");
    look(202, 3'd1, 8'hF9, "new1");
    look(218, 3'd3, 8'hB0, "new3");
    look(250, 3'd7, 8'hF8, "new7");

    // Digit 3 disabled
    run_to(252);
    do_load(32'h76543210, 8'h00, 8'hF7);
    look(274, 3'd2, 8'hA4, "en2");
    for (int c = 0; c < 8; c++) look(280 + c, 3'd3, 8'hFF, $sformatf("dark3_%0d", c));
    look(290, 3'd4, 8'h99, "en4");

    // Last of two loads wins
    run_to(292);
    do_load(32'h12345678, 8'h00, 8'hFF);
    run_to(300);
    do_load(32'h9ABCDEF0, 8'h00, 8'hFF);
    look(322, 3'd0, 8'hC0, "last0");
    look(330, 3'd1, 8'h8E, "last1");
    look(378, 3'd7, 8'h90, "last7");

    // Load in the boundary cycle itself
    look(383, 3'd7, 8'h90, "pre_bnd");
    do_load(32'hFEDCBA98, 8'h00, 8'hFF);
    look(384, 3'd0, 8'hFF, "bnd_edge");
    look(386, 3'd0, 8'h80, "bnd0");
    look(394, 3'd1, 8'h90, "bnd1");
    look(450, 3'd0, 8'h80, "bnd_next");

    // Async reset mid-SHOW with pending data
    run_to(452);
    do_load(32'h11111111, 8'h00, 8'hFF);
    look(460, 3'd1, 8'h90, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.seg", bus.seg, 8'hFF);
    chk("arst.sel", bus.sel, 3'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    look(2, 3'd0, 8'hC0, "post0");
    look(10, 3'd1, 8'hC0, "post1");
    look(66, 3'd0, 8'hC0, "discard");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
